// File: rtl/gfx_bank_scheduler_if.sv
// Requester-side handshake bundle for gfx_bank_scheduler: NUM_RD scanline readers plus one DMA writer.
interface gfx_bank_scheduler_if #(
  parameter int NUM_RD            = 4,
  parameter int BITS              = 16,
  parameter int BANK_ADDRESS_BITS = 14
) ();
  logic [NUM_RD*BANK_ADDRESS_BITS-1:0] rd_addr;
  logic [NUM_RD-1:0]                   rd_valid;
  logic [NUM_RD-1:0]                   rd_ready;
  logic [BITS-1:0]                     rd_data;
  logic [BANK_ADDRESS_BITS-1:0]        wr_addr;
  logic [BITS-1:0]                     wr_data;
  logic                                wr_valid;
  logic                                wr_ready;

  modport master (
    output rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
    input  rd_ready, rd_data, wr_ready
  );

  modport slave (
    input  rd_addr, rd_valid, wr_addr, wr_data, wr_valid,
    output rd_ready, rd_data, wr_ready
  );
endinterface

// File: rtl/gfx_bank_scheduler.sv
// Round-robin readers / low-priority anti-starved writer sharing one graphics bank port.
// Define GFX_BANK_SCHEDULER_STATS_EN to enable the per-frame bank-busy counter on stat_busy.
module gfx_bank_scheduler #(
  parameter int NUM_RD            = 4,
  parameter int BITS              = 16,
  parameter int BANK_ADDRESS_BITS = 14,
  parameter int WR_MAX_WAIT       = 8
) (
  input  logic                         CLK,
  input  logic                         RSTb,
  gfx_bank_scheduler_if.slave          req,
  output logic [BANK_ADDRESS_BITS-1:0] B_ADDR,
  input  logic [BITS-1:0]              B_DIN,
  output logic                         B_REQ,
  output logic [BITS-1:0]              B_DOUT,
  output logic                         B_WR,
  input  logic                         frame_tick,
  output logic [15:0]                  stat_busy
);

  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam logic [7:0] WAIT_MAX = 8'(WR_MAX_WAIT);

  typedef enum logic [1:0] {ARB, ACCESS, CAPTURE} state_t;

  state_t                       state, state_next;
  logic [IDX_W-1:0]             ptr, lat_idx, pick_idx;
  logic [7:0]                   wr_wait;
  logic [BANK_ADDRESS_BITS-1:0] lat_addr;
  logic [BITS-1:0]              lat_data, rd_data_q;
  logic                         lat_wr;
  logic [NUM_RD-1:0]            rd_ready_q, eligible;
  logic                         pick_found, grant_rd, grant_wr;
  int                           cand;

  // A reader showing rd_ready this cycle is masked so it cannot be granted twice.
  always_comb begin
    eligible   = req.rd_valid & ~rd_ready_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_RD; k++) begin
      cand = (int'(ptr) + k) % NUM_RD;
      if (!pick_found && eligible[IDX_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_next   = state;
    grant_rd     = 1'b0;
    grant_wr     = 1'b0;
    B_REQ        = 1'b0;
    B_ADDR       = '0;
    B_WR         = 1'b0;
    B_DOUT       = '0;
    req.wr_ready = 1'b0;
    case (state)
      ARB: begin
        if (req.wr_valid && (!pick_found || wr_wait == WAIT_MAX)) begin
          grant_wr   = 1'b1;
          state_next = ACCESS;
        end else if (pick_found) begin
          grant_rd   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        B_REQ  = 1'b1;
        B_ADDR = lat_addr;
        if (lat_wr) begin
          B_WR         = 1'b1;
          B_DOUT       = lat_data;
          req.wr_ready = 1'b1;
          state_next   = ARB;
        end else begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        B_REQ      = 1'b1;
        B_ADDR     = lat_addr;
        state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  // Grant latching keeps the in-flight transaction immune to later request-side changes.
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      state      <= ARB;
      ptr        <= IDX_W'(NUM_RD - 1);
      wr_wait    <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
      lat_idx    <= '0;
      rd_ready_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state      <= state_next;
      rd_ready_q <= '0;
      if (grant_wr) begin
        lat_wr   <= 1'b1;
        lat_addr <= req.wr_addr;
        lat_data <= req.wr_data;
        wr_wait  <= '0;
      end else if (grant_rd) begin
        lat_wr   <= 1'b0;
        lat_addr <= req.rd_addr[pick_idx*BANK_ADDRESS_BITS +: BANK_ADDRESS_BITS];
        lat_data <= '0;
        lat_idx  <= pick_idx;
        ptr      <= pick_idx;
        if (req.wr_valid && wr_wait != WAIT_MAX) wr_wait <= wr_wait + 8'd1;
      end
      if (state == CAPTURE) begin
        rd_data_q           <= B_DIN;
        rd_ready_q[lat_idx] <= 1'b1;
      end
    end
  end

  assign req.rd_ready = rd_ready_q;
  assign req.rd_data  = rd_data_q;

`ifdef GFX_BANK_SCHEDULER_STATS_EN
  logic [15:0] busy_cnt;

  // A frame_tick landing on a busy cycle counts that cycle toward the new frame.
  always_ff @(posedge CLK) begin
    if (RSTb) begin
      busy_cnt  <= '0;
      stat_busy <= '0;
    end else if (frame_tick) begin
      stat_busy <= busy_cnt;
      busy_cnt  <= B_REQ ? 16'd1 : 16'd0;
    end else if (B_REQ && busy_cnt != 16'hFFFF) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end
`else
  logic unused_frame_tick;
  assign unused_frame_tick = frame_tick;
  assign stat_busy         = '0;
`endif

endmodule

// File: tb/tb_gfx_bank_scheduler.sv
// Directed bench for gfx_bank_scheduler: transaction-level model checked every cycle plus literal checks.
module tb_gfx_bank_scheduler;
  localparam int NUM_RD = 4;
  localparam int BITS   = 16;
  localparam int BAB    = 14;
  localparam int WMAX   = 8;

  logic             CLK = 1'b0;
  logic             RSTb = 1'b1;
  logic [BAB-1:0]   B_ADDR;
  logic [BITS-1:0]  B_DIN = '0;
  logic             B_REQ, B_WR;
  logic [BITS-1:0]  B_DOUT;
  logic             frame_tick = 1'b0;
  logic [15:0]      stat_busy;

  always #5 CLK = ~CLK;

  gfx_bank_scheduler_if #(.NUM_RD(NUM_RD), .BITS(BITS), .BANK_ADDRESS_BITS(BAB)) bus ();

  gfx_bank_scheduler #(.NUM_RD(NUM_RD), .BITS(BITS), .BANK_ADDRESS_BITS(BAB), .WR_MAX_WAIT(WMAX)) dut (
    .CLK(CLK), .RSTb(RSTb), .req(bus),
    .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_REQ(B_REQ), .B_DOUT(B_DOUT), .B_WR(B_WR),
    .frame_tick(frame_tick), .stat_busy(stat_busy)
  );

  function automatic logic [BITS-1:0] bank_read(input logic [BAB-1:0] a);
    return {2'b00, a} ^ 16'hBFCC;
  endfunction

  // Synchronous-read bank: data for an address appears one cycle later.
  always @(posedge CLK) B_DIN <= bank_read(B_ADDR);

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 = arbitrating, 1 = bank access, 2 = read data capture.
  int              m_phase = 0, m_idx = 0, m_last = NUM_RD - 1, m_lost = 0;
  logic            m_is_wr = 1'b0;
  logic [BAB-1:0]  m_addr = '0;
  logic [BITS-1:0] m_data = '0, m_rdata = '0;
  logic [NUM_RD-1:0] m_pulse = '0, m_elig, m_next_pulse;
  logic [15:0]     m_cnt = '0, m_stat = '0;
  bit              m_init = 0, m_busy_now;
  int              m_pick;
  int              grant_log[$];

  always @(posedge CLK) begin
    m_busy_now = (m_phase != 0);
    if (RSTb) begin
      m_phase = 0; m_last = NUM_RD - 1; m_lost = 0; m_pulse = '0; m_rdata = '0;
      m_cnt = '0; m_stat = '0; m_init = 1;
    end else begin
`ifdef GFX_BANK_SCHEDULER_STATS_EN
      if (frame_tick) begin
        m_stat = m_cnt;
        m_cnt  = m_busy_now ? 16'd1 : 16'd0;
      end else if (m_busy_now && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      m_next_pulse = '0;
      if (m_phase == 0) begin
        m_elig = bus.rd_valid & ~m_pulse;
        m_pick = -1;
        for (int k = 1; k <= NUM_RD; k++)
          if (m_pick < 0 && m_elig[(m_last + k) % NUM_RD]) m_pick = (m_last + k) % NUM_RD;
        if (bus.wr_valid && (m_pick < 0 || m_lost == WMAX)) begin
          m_phase = 1; m_is_wr = 1'b1; m_addr = bus.wr_addr; m_data = bus.wr_data; m_lost = 0;
          grant_log.push_back(-1);
        end else if (m_pick >= 0) begin
          m_phase = 1; m_is_wr = 1'b0; m_addr = bus.rd_addr[m_pick*BAB +: BAB];
          m_idx = m_pick; m_last = m_pick;
          if (bus.wr_valid && m_lost < WMAX) m_lost++;
          grant_log.push_back(m_pick);
        end
      end else if (m_phase == 1) begin
        m_phase = m_is_wr ? 0 : 2;
      end else begin
        m_rdata = bank_read(m_addr);
        m_next_pulse[m_idx] = 1'b1;
        m_phase = 0;
      end
      m_pulse = m_next_pulse;
    end
  end

  int                cycle = 0;
  logic [NUM_RD-1:0] pulse_log[$];
  int                pulse_cyc[$];
  int                wr_cyc[$];

  // Every-cycle comparison of the DUT against the model, plus an observation log for literal checks.
  always @(negedge CLK) begin
    if (m_init) begin
      cycle++;
      checkOutput("B_REQ",    32'(B_REQ),        32'(m_phase != 0));
      checkOutput("B_ADDR",   32'(B_ADDR),       (m_phase != 0) ? 32'(m_addr) : 32'd0);
      checkOutput("B_WR",     32'(B_WR),         32'(m_phase == 1 && m_is_wr));
      checkOutput("B_DOUT",   32'(B_DOUT),       (m_phase == 1 && m_is_wr) ? 32'(m_data) : 32'd0);
      checkOutput("wr_ready", 32'(bus.wr_ready), 32'(m_phase == 1 && m_is_wr));
      checkOutput("rd_ready", 32'(bus.rd_ready), 32'(m_pulse));
      checkOutput("rd_data",  32'(bus.rd_data),  32'(m_rdata));
      checkOutput("stat_busy", 32'(stat_busy),   32'(m_stat));
      if (bus.rd_ready != '0) begin
        pulse_log.push_back(bus.rd_ready);
        pulse_cyc.push_back(cycle);
      end
      if (bus.wr_ready) wr_cyc.push_back(cycle);
    end
  end

  bit                auto_rd = 0;
  logic [NUM_RD-1:0] want = '0;

  // Auto readers drop their request during their own rd_ready cycle and re-raise it afterwards.
  always @(posedge CLK) begin
    #1;
    if (auto_rd) bus.rd_valid = want & ~bus.rd_ready;
  end

  task automatic applyStimulus(input logic [NUM_RD-1:0] rv, input logic wv);
    @(posedge CLK); #1;
    bus.rd_valid = rv;
    bus.wr_valid = wv;
  endtask

  task automatic doReset();
    auto_rd = 0; want = '0;
    bus.rd_valid = '0; bus.wr_valid = 1'b0;
    RSTb = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RSTb = 1'b0;
    pulse_log.delete(); pulse_cyc.delete(); wr_cyc.delete(); grant_log.delete();
  endtask

  int n, base, cnt_a, cnt_b, first_wr;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [NUM_RD-1:0] one_hot;

  initial begin
    bus.rd_addr = '0; bus.rd_valid = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;

    // Single read to reader 0
    doReset();
    bus.rd_addr[0 +: BAB] = 14'h0123;
    bus.rd_valid = 4'b0001;
    @(negedge CLK); checkOutput("t1_c0_breq", 32'(B_REQ), 32'd0);
    @(negedge CLK); checkOutput("t1_c1_breq", 32'(B_REQ), 32'd1);
                    checkOutput("t1_c1_addr", 32'(B_ADDR), 32'h0123);
    @(negedge CLK); checkOutput("t1_c2_addr", 32'(B_ADDR), 32'h0123);
    @(negedge CLK); checkOutput("t1_c3_rdy",  32'(bus.rd_ready), 32'b0001);
                    checkOutput("t1_c3_data", 32'(bus.rd_data), 32'hBEEF);
                    checkOutput("t1_c3_breq", 32'(B_REQ), 32'd0);
    @(negedge CLK); checkOutput("t1_c4_rdy",  32'(bus.rd_ready), 32'd0);
                    checkOutput("t1_c4_breq", 32'(B_REQ), 32'd0);
    applyStimulus('0, 1'b0);
    repeat (3) @(posedge CLK);

    // All readers valid: round-robin order and 3-cycle spacing
    doReset();
    for (int i = 0; i < NUM_RD; i++) bus.rd_addr[i*BAB +: BAB] = 14'(14'h0100 * (i + 1) + i);
    want = 4'hF; auto_rd = 1; bus.rd_valid = 4'hF;
    n = 0;
    while (pulse_log.size() < 5 && n < 40) begin @(negedge CLK); #1; n++; end
    checkOutput("t2_done", 32'(pulse_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < pulse_log.size(); i++) begin
      one_hot = 4'b0001 << exp_order[i];
      checkOutput("t2_order", 32'(pulse_log[i]), 32'(one_hot));
      if (i < grant_log.size()) checkOutput("t2_model_order", 32'(grant_log[i]), 32'(exp_order[i]));
      if (i > 0) checkOutput("t2_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd3);
    end
    auto_rd = 0; want = '0;
    applyStimulus('0, 1'b0);
    repeat (4) @(posedge CLK);

    // Lone write
    doReset();
    bus.wr_addr = 14'h3FFF; bus.wr_data = 16'h5A5A; bus.wr_valid = 1'b1;
    @(negedge CLK); checkOutput("t3_c0_wrr",  32'(bus.wr_ready), 32'd0);
    @(negedge CLK); checkOutput("t3_c1_bwr",  32'(B_WR), 32'd1);
                    checkOutput("t3_c1_addr", 32'(B_ADDR), 32'h3FFF);
                    checkOutput("t3_c1_dout", 32'(B_DOUT), 32'h5A5A);
                    checkOutput("t3_c1_wrr",  32'(bus.wr_ready), 32'd1);
    applyStimulus('0, 1'b0);
    @(negedge CLK); checkOutput("t3_c2_bwr",  32'(B_WR), 32'd0);
    repeat (2) @(posedge CLK);

    // Write starvation guard under full reader load
    doReset();
    base = cycle + 1;
    want = 4'hF; auto_rd = 1; bus.rd_valid = 4'hF;
    bus.wr_addr = 14'h1234; bus.wr_data = 16'hC3C3; bus.wr_valid = 1'b1;
    n = 0;
    while (wr_cyc.size() < 2 && n < 80) begin @(negedge CLK); #1; n++; end
    checkOutput("t4_done", 32'(wr_cyc.size() >= 2), 32'd1);
    auto_rd = 0; want = '0;
    applyStimulus('0, 1'b0);
    if (wr_cyc.size() >= 2) begin
      cnt_a = 0; cnt_b = 0;
      foreach (pulse_cyc[i]) begin
        if (pulse_cyc[i] < wr_cyc[0]) cnt_a++;
        else if (pulse_cyc[i] < wr_cyc[1]) cnt_b++;
      end
      checkOutput("t4_reads_before_wr1", 32'(cnt_a), 32'd8);
      checkOutput("t4_reads_between",    32'(cnt_b), 32'd8);
      checkOutput("t4_wr1_cycle",        32'(wr_cyc[0] - base), 32'd25);
      checkOutput("t4_wr_gap",           32'(wr_cyc[1] - wr_cyc[0]), 32'd26);
    end
    first_wr = -1;
    foreach (grant_log[i]) if (first_wr < 0 && grant_log[i] == -1) first_wr = i;
    checkOutput("t4_model_first_wr", 32'(first_wr), 32'd8);
    repeat (4) @(posedge CLK);

    // Reset during CAPTURE of a reader-2 read
    doReset();
    bus.rd_addr[2*BAB +: BAB] = 14'h2222;
    bus.rd_addr[0 +: BAB] = 14'h0042;
    bus.rd_valid = 4'b0100;
    @(posedge CLK); #1;
    @(posedge CLK); #1; RSTb = 1'b1;
    @(posedge CLK); #1; RSTb = 1'b0; bus.rd_valid = 4'b0101;
    pulse_log.delete();
    @(negedge CLK);
    checkOutput("t5_rdy",   32'(bus.rd_ready), 32'd0);
    checkOutput("t5_breq",  32'(B_REQ), 32'd0);
    checkOutput("t5_addr",  32'(B_ADDR), 32'd0);
    checkOutput("t5_rdata", 32'(bus.rd_data), 32'd0);
    n = 0;
    while (pulse_log.size() < 1 && n < 20) begin @(negedge CLK); #1; n++; end
    checkOutput("t5_done", 32'(pulse_log.size() >= 1), 32'd1);
    if (pulse_log.size() >= 1) checkOutput("t5_first_winner", 32'(pulse_log[0]), 32'b0001);
    applyStimulus('0, 1'b0);
    repeat (6) @(posedge CLK);

    // Frame statistics: 10 reads between two frame ticks
    doReset();
    frame_tick = 1'b1;
    bus.rd_addr[1*BAB +: BAB] = 14'h0777;
    want = 4'b0010; auto_rd = 1; bus.rd_valid = 4'b0010;
    @(posedge CLK); #1 frame_tick = 1'b0;
    n = 0;
    while (pulse_log.size() < 10 && n < 80) begin @(negedge CLK); #1; n++; end
    want = '0;
    checkOutput("t6_done", 32'(pulse_log.size()), 32'd10);
    repeat (3) @(posedge CLK);
    #1 auto_rd = 0; frame_tick = 1'b1;
    @(posedge CLK); #1 frame_tick = 1'b0;
    @(negedge CLK);
`ifdef GFX_BANK_SCHEDULER_STATS_EN
    checkOutput("t6_stat_busy", 32'(stat_busy), 32'd20);
`else
    checkOutput("t6_stat_busy", 32'(stat_busy), 32'd0);
`endif
    repeat (2) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/gfx_bank_scheduler.md
Name: gfx_bank_scheduler

Overview:
- Shares one 16-bit graphics memory bank port between NUM_RD scanline read requesters (sprite, bg0, bg1, fb) and one write requester (SPI flash DMA).
- Readers are served round-robin.
- The flash write port has lowest priority, with an anti-starvation counter.
- One instance sits between the gfx requesters and each B*_ bank port.

Parameters:
- NUM_RD, 4, number of read requesters.
- BITS, 16, data width.
- BANK_ADDRESS_BITS, 14, bank word address width.
- WR_MAX_WAIT, 8, number of ARB cycles a pending write may lose before it is forced (valid range 1..255).

Ports:
- CLK  in  1  clock.
- RSTb  in  1  reset; synchronous, active-high (port keeps the codebase name RSTb).
- rd_addr  in  NUM_RD*BANK_ADDRESS_BITS  packed read addresses; requester i uses bits [i*BANK_ADDRESS_BITS +: BANK_ADDRESS_BITS].
- rd_valid  in  NUM_RD  read request; held high until the matching rd_ready.
- rd_ready  out  NUM_RD  one-cycle completion pulse per requester.
- rd_data  out  BITS  read data; valid while any rd_ready bit is high.
- wr_addr  in  BANK_ADDRESS_BITS  write address.
- wr_data  in  BITS  write data.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted; transfer occurs when wr_valid and wr_ready are both high at a clock edge.
- B_ADDR  out  BANK_ADDRESS_BITS  bank address.
- B_DIN  in  BITS  bank read data; valid one cycle after the address is presented.
- B_REQ  out  1  bank owned by gfx.
- B_DOUT  out  BITS  bank write data.
- B_WR  out  1  bank write strobe.
- frame_tick  in  1  one-cycle pulse at frame start (V_tick).
- stat_busy  out  16  bank-busy cycle count for the previous frame; see Optional Feature.

Behaviour:
- FSM states: ARB, ACCESS, CAPTURE.
- Reset (RSTb=1 at a clock edge):
  - state = ARB.
  - rd_ready = 0, rd_data = 0, wr_ready = 0.
  - B_REQ = 0, B_WR = 0, B_ADDR = 0, B_DOUT = 0.
  - Round-robin pointer = NUM_RD-1, so reader 0 wins first.
  - wr_wait = 0, stat_busy = 0.
  - Reset mid-transaction abandons it: no rd_ready or wr_ready is issued, and the requester must re-request.
- ARB:
  - Eligible readers are those with rd_valid=1 AND rd_ready=0 in this cycle. This masking prevents a double grant on the completion cycle.
  - If wr_valid=1 and (no eligible reader or wr_wait==WR_MAX_WAIT), grant the write and clear wr_wait.
  - Otherwise, if any eligible reader exists, grant the first eligible index searching upward (modulo NUM_RD) from pointer+1. The pointer takes the granted index. wr_wait increments, saturating, if wr_valid=1.
  - On any grant, latch address, data, write flag and grant index; next state = ACCESS.
  - With no grant, stay in ARB with B_REQ=0.
- ACCESS:
  - B_REQ=1 and B_ADDR=latched address.
  - Write grant: B_WR=1, B_DOUT=latched data, wr_ready=1 in this cycle; next state = ARB.
  - Read grant: B_WR=0, B_DOUT=0; next state = CAPTURE.
- CAPTURE:
  - B_REQ=1, B_ADDR is held, B_WR=0.
  - At the clock edge, rd_data <= B_DIN and rd_ready[grant] <= 1 (registered). The pulse therefore appears in the following ARB cycle and lasts exactly one cycle.
  - Next state = ARB.
- Timing:
  - Read: rd_valid sampled in ARB at cycle 0 → rd_ready and rd_data at cycle 3. Reader throughput is 1 per 3 cycles.
  - Write: accepted at cycle 1 (wr_ready). Write throughput is 1 per 2 cycles.
- rd_data holds its last value between completions.
- Changes to rd_addr/wr_addr after a grant have no effect on the transaction in flight.
- Simultaneous all-valid: readers are served in the order 0,1,2,3,0,… Each completing reader is masked in its own rd_ready cycle.
- Pointer wrap: from pointer NUM_RD-1 the search starts at index 0.
- The saturated wr_wait forces the write even when all readers are valid.

Optional Feature:
- Macro: GFX_BANK_SCHEDULER_STATS_EN.
- Enabled:
  - A 16-bit counter increments, saturating at 0xFFFF, on each cycle with B_REQ=1.
  - On frame_tick, stat_busy <= counter and the counter resets to 0; if B_REQ=1 in that cycle, it resets to 1.
  - Reset clears both the counter and stat_busy.
- Disabled: stat_busy is tied to 0, no counter exists, and frame_tick is unused.

Test Plan:
- Reset, then rd_valid=0001 with rd_addr[0]=0x0123 and the bank model returning 0xBEEF one cycle after each address → B_REQ/B_ADDR=0x0123 at cycles 1-2; rd_ready=0001 and rd_data=0xBEEF at cycle 3, one cycle only; no second grant at cycle 3.
- rd_valid=1111 held (each requester drops its request on its own rd_ready, re-raises next cycle) → grants in order 0,1,2,3,0; rd_ready pulses every 3 cycles.
- wr_valid=1 with wr_addr=0x3FFF, wr_data=0x5A5A, no readers → B_WR=1, B_ADDR=0x3FFF, B_DOUT=0x5A5A, wr_ready=1 in the same cycle, one cycle after request.
- rd_valid=1111 held plus wr_valid=1, WR_MAX_WAIT=8 → 8 reader grants, then write granted on the 9th ARB cycle and wr_wait cleared.
- Assert RSTb in CAPTURE of a read to reader 2 → no rd_ready[2], all outputs 0 next cycle, and reader 0 wins first afterwards.
- With GFX_BANK_SCHEDULER_STATS_EN defined: 10 reads between two frame_tick pulses → stat_busy=20 after the second tick. With the macro undefined, stat_busy stays 0.
